mem_rr_ctrl: RTL and testbench

Parametrised multi-channel memory controller. It serves NUM_CH independent requesters, each using the team's wr_rd/addr/wdata/valid/ready/rdata handshake. A round-robin arbiter grants one request per cycle into a single DEPTH x WIDTH storage array. Reads return registered data with a per-channel rvalid strobe, and out-of-range accesses are flagged. It replaces the single-channel memory as the DUT for the memory testbench.

---
 rtl/mem_rr_ctrl.sv | 91 +++++++++
 tb/tb_mem_rr_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_rr_ctrl.sv
// Multi-channel single-port memory with a round-robin arbiter.
// One grant per cycle; reads return registered data with a per-channel strobe.
module mem_rr_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            wr_rd,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*WIDTH-1:0]      wdata,
    input  logic [NUM_CH-1:0]            valid,
    output logic [NUM_CH-1:0]            ready,
    output logic [NUM_CH*WIDTH-1:0]      rdata,
    output logic [NUM_CH-1:0]            rvalid,
    output logic [NUM_CH-1:0]            err
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      idx;
    logic                  found;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range;
    logic                  xfer;

    // Walk downward so the channel closest to ptr is the last one written.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CH);
            if (valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign xfer = rst && found;

    always_comb begin
        ready = '0;
        if (xfer)
            ready[win] = 1'b1;
    end

    assign sel_wr    = wr_rd[win];
    assign sel_addr  = addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = wdata[win*WIDTH +: WIDTH];
    assign mem_idx   = sel_addr[IDX_W-1:0];
    assign in_range  = {1'b0, sel_addr} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (xfer && sel_wr && in_range)
            mem[mem_idx] <= sel_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            rdata  <= '0;
            rvalid <= '0;
            err    <= '0;
        end else begin
            rvalid <= '0;
            err    <= '0;
            if (found) begin
                ptr <= (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
                err[win] <= !in_range;
                if (!sel_wr) begin
                    rvalid[win] <= 1'b1;
                    rdata[win*WIDTH +: WIDTH] <=
                        in_range ? mem[mem_idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_ctrl.sv
// Directed bench for mem_rr_ctrl: two channels, DEPTH = 12.
// Vectors drive one cycle each; registered outputs reflect the previous edge.
module tb_mem_rr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_rd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [15:0] rdata;
    logic [1:0]  rvalid;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    mem_rr_ctrl #(
        .WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_CH(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata), .valid(valid), .ready(ready),
        .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [1:0]  v;
        logic [1:0]  w;
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  e_ready;
        logic [1:0]  e_rvalid;
        logic [1:0]  e_err;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic [1:0] v, input logic [1:0] w,
        input logic [7:0] a, input logic [15:0] d,
        input logic [1:0] er, input logic [1:0] ev,
        input logic [1:0] ee, input logic [15:0] ed);
        vec_t t;
        t.r = r; t.v = v; t.w = w; t.a = a; t.d = d;
        t.e_ready = er; t.e_rvalid = ev; t.e_err = ee; t.e_rdata = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v,
                         input logic [1:0] w, input logic [7:0] a,
                         input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r; valid = v; wr_rd = w; addr = a; wdata = d;
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        int n0;
        int n1;
        logic [1:0] exp_g;
        rst = 1'b0; valid = '0; wr_rd = '0; addr = '0; wdata = '0;

        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 2'b11, 2'b00, 8'h00, 16'h0000,
                             2'b00, 2'b00, 2'b00, 16'h0000));
        tbl.push_back(mk(1, 2'b01, 2'b01, 8'h03, 16'h00A5,
                         2'b01, 2'b00, 2'b00, 16'h0000));
        tbl.push_back(mk(1, 2'b01, 2'b00, 8'h03, 16'h0000,
                         2'b01, 2'b00, 2'b00, 16'h0000));
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 16'h0000,
                         2'b00, 2'b01, 2'b00, 16'h00A5));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 16'h0000,
                             2'b00, 2'b00, 2'b00, 16'h00A5));
        tbl.push_back(mk(1, 2'b01, 2'b01, 8'h05, 16'h0011,
                         2'b01, 2'b00, 2'b00, 16'h00A5));
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'hB0, 16'h5A00,
                         2'b10, 2'b00, 2'b00, 16'h00A5));
        tbl.push_back(mk(1, 2'b11, 2'b10, 8'h55, 16'h3C00,
                         2'b01, 2'b00, 2'b00, 16'h00A5));
        tbl.push_back(mk(1, 2'b11, 2'b10, 8'h55, 16'h3C00,
                         2'b10, 2'b01, 2'b00, 16'h0011));
        tbl.push_back(mk(1, 2'b01, 2'b00, 8'h05, 16'h0000,
                         2'b01, 2'b00, 2'b00, 16'h0011));
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 16'h0000,
                         2'b00, 2'b01, 2'b00, 16'h003C));
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'hE0, 16'hFF00,
                         2'b10, 2'b00, 2'b00, 16'h003C));
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'hB0, 16'h0000,
                         2'b10, 2'b00, 2'b10, 16'h003C));
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'hE0, 16'h0000,
                         2'b10, 2'b10, 2'b00, 16'h5A3C));
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 16'h0000,
                         2'b00, 2'b10, 2'b10, 16'h003C));
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 16'h0000,
                         2'b00, 2'b00, 2'b00, 16'h003C));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("r%0d ready", i), 32'(ready),
                32'(tbl[i].e_ready));
            chk($sformatf("r%0d rvalid", i), 32'(rvalid),
                32'(tbl[i].e_rvalid));
            chk($sformatf("r%0d err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("r%0d rdata", i), 32'(rdata),
                32'(tbl[i].e_rdata));
        end

        // Both channels streaming writes: grants must alternate from ch0.
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, 2'b11, 2'b11,
                  {4'(6 + n1), 4'(n0)},
                  {8'(8'h70 + n1), 8'(8'h60 + n0)});
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr grant %0d", c), 32'(ready), 32'(exp_g));
            if (ready[0]) n0++;
            if (ready[1]) n1++;
        end

        drive(1, 2'b11, 2'b00, 8'h81, 16'h0000);
        chk("rr rd0 ready", 32'(ready), 32'h1);
        drive(1, 2'b10, 2'b00, 8'h81, 16'h0000);
        chk("rr rd1 ready", 32'(ready), 32'h2);
        chk("rr rd0 rvalid", 32'(rvalid), 32'h1);
        chk("rr rd0 data", 32'(rdata[7:0]), 32'h61);
        drive(1, 2'b00, 2'b00, 8'h00, 16'h0000);
        chk("rr rd1 rvalid", 32'(rvalid), 32'h2);
        chk("rr rd1 data", 32'(rdata[15:8]), 32'h72);

        // Move ptr to 1, then reset while ch0 presents a read.
        drive(1, 2'b01, 2'b01, 8'h00, 16'h0011);
        chk("pre-rst ready", 32'(ready), 32'h1);
        drive(0, 2'b01, 2'b00, 8'h01, 16'h0000);
        chk("in-rst ready", 32'(ready), 32'h0);
        drive(1, 2'b11, 2'b00, 8'h11, 16'h0000);
        chk("post-rst rvalid", 32'(rvalid), 32'h0);
        chk("post-rst rdata", 32'(rdata), 32'h0);
        chk("post-rst grant", 32'(ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
